// File: rtl/ecall_pkg.sv
// ecall_pkg -- shared definitions for the ecall sequencer.
//   * default widths and latency for the sequencer parameters
//   * architectural constants: a0 register index, exit syscall number
//   * sequencer state encoding
package ecall_pkg;

    localparam int DEFAULT_DATA_WIDTH     = 64;
    localparam int DEFAULT_ADDR_WIDTH     = 64;
    localparam int DEFAULT_RESULT_LATENCY = 1;

    // Down-counter width; covers RESULT_LATENCY up to 15.
    localparam int WAIT_CNT_WIDTH = 4;

    localparam logic [4:0] A0_REG   = 5'd10;
    localparam int         SYS_EXIT = 93;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DRAIN    = 3'd1,
        ST_CALL     = 3'd2,
        ST_WAIT     = 3'd3,
        ST_WB       = 3'd4,
        ST_REDIRECT = 3'd5,
        ST_HALTED   = 3'd6
    } ecall_state_t;

endpackage

// File: rtl/ecall_sequencer.sv
// ecall_sequencer -- sequences a committed ECALL through the ecall unit.
//
// Flow: accept (ack) -> drain memory -> trigger ecall unit -> wait for the
// result -> write a0 -> flush + redirect fetch to pc+4 -> idle, or halt
// permanently when the syscall number is the exit call.
//
// Ports:
//   clk, reset          clock; synchronous active-low reset
//   ecall_req/pc/a7     committed ECALL from writeback (req held until ack)
//   ecall_ack           one-cycle accept pulse
//   stall               freezes fetch/decode/execute (every state but idle)
//   mem_drain_req       D-cache write-back request while draining
//   mem_idle            memory system quiescent
//   ecall_trigger       one-cycle start pulse to the ecall unit
//   ecall_result        a0 value from the ecall unit
//   rf_we/waddr/wdata   a0 register-file write
//   flush               one-cycle pipeline flush
//   redirect_valid/pc   one-cycle fetch redirect to ecall pc + 4
//   halt                sticky after the exit syscall
//   ecall_count         completed ecalls (wraps at 32 bits)
//
// Every output is either a register or a decode of the state register, so
// nothing reaches an output combinationally from ecall_req.
module ecall_sequencer
    import ecall_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int RESULT_LATENCY = DEFAULT_RESULT_LATENCY,  // 1..15
    parameter int EXIT_SYSCALL   = SYS_EXIT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ecall_req,
    input  logic [ADDR_WIDTH-1:0] ecall_pc,
    input  logic [DATA_WIDTH-1:0] ecall_a7,
    output logic                  ecall_ack,
    output logic                  stall,
    output logic                  mem_drain_req,
    input  logic                  mem_idle,
    output logic                  ecall_trigger,
    input  logic [DATA_WIDTH-1:0] ecall_result,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  flush,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halt,
    output logic [31:0]           ecall_count
);

    localparam logic [WAIT_CNT_WIDTH-1:0] WAIT_LOAD =
        WAIT_CNT_WIDTH'(RESULT_LATENCY - 1);
    localparam logic [DATA_WIDTH-1:0] EXIT_NUM = DATA_WIDTH'(EXIT_SYSCALL);

    ecall_state_t              state_reg;
    ecall_state_t              state_next;
    logic                      ack_reg;
    logic [ADDR_WIDTH-1:0]     pc_reg;
    logic [DATA_WIDTH-1:0]     a7_reg;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_reg;
    logic [DATA_WIDTH-1:0]     rf_wdata_reg;
    logic [ADDR_WIDTH-1:0]     redirect_pc_reg;
    logic                      halt_reg;
    logic [31:0]               count_reg;

    logic accept;
    logic is_exit;

    assign accept  = (state_reg == ST_IDLE) && ecall_req && !halt_reg;
    assign is_exit = (a7_reg == EXIT_NUM);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The first drain cycle is the ack cycle; mem_idle is only
                // honoured after it, which gives the drain its minimum of one
                // full cycle beyond the accept.
                if (mem_idle && !ack_reg) begin
                    state_next = ST_CALL;
                end
            end
            ST_CALL: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_cnt_reg == '0) begin
                    state_next = ST_WB;
                end
            end
            ST_WB: begin
                state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                state_next = is_exit ? ST_HALTED : ST_IDLE;
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            ack_reg         <= 1'b0;
            pc_reg          <= '0;
            a7_reg          <= '0;
            wait_cnt_reg    <= '0;
            rf_wdata_reg    <= '0;
            redirect_pc_reg <= '0;
            halt_reg        <= 1'b0;
            count_reg       <= '0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= accept;

            if (accept) begin
                pc_reg <= ecall_pc;
                a7_reg <= ecall_a7;
            end

            case (state_reg)
                ST_CALL: begin
                    wait_cnt_reg <= WAIT_LOAD;
                end
                ST_WAIT: begin
                    // Capture on the cycle the counter hits zero: that is
                    // exactly RESULT_LATENCY cycles after the trigger cycle.
                    if (wait_cnt_reg == '0) begin
                        rf_wdata_reg <= ecall_result;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                ST_WB: begin
                    // Wraps modulo 2^ADDR_WIDTH by construction.
                    redirect_pc_reg <= pc_reg + ADDR_WIDTH'(4);
                end
                ST_REDIRECT: begin
                    count_reg <= count_reg + 32'd1;
                    if (is_exit) begin
                        halt_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ecall_ack      = ack_reg;
    assign stall          = (state_reg != ST_IDLE);
    assign mem_drain_req  = (state_reg == ST_DRAIN);
    assign ecall_trigger  = (state_reg == ST_CALL);
    assign rf_we          = (state_reg == ST_WB);
    assign rf_waddr       = rf_we ? A0_REG : 5'd0;
    assign rf_wdata       = rf_wdata_reg;
    assign flush          = (state_reg == ST_REDIRECT);
    assign redirect_valid = (state_reg == ST_REDIRECT);
    assign redirect_pc    = redirect_pc_reg;
    assign halt           = halt_reg;
    assign ecall_count    = count_reg;

endmodule

// File: tb/tb_ecall_sequencer.sv
// Testbench for ecall_sequencer. One instance with RESULT_LATENCY=1 runs a
// table of per-cycle vectors plus drain, exit and reset sequences; a second
// instance with RESULT_LATENCY=3 covers capture timing and pc wrap.
module tb_ecall_sequencer;

    logic        clk;
    logic        reset;

    // Instance with RESULT_LATENCY = 1
    logic        req;
    logic [63:0] pc;
    logic [63:0] a7;
    logic        idle;
    logic [63:0] result;
    logic        ack, stall, drain, trig, we, flush, rv, halt;
    logic [4:0]  waddr;
    logic [63:0] wdata, rpc;
    logic [31:0] count;

    // Instance with RESULT_LATENCY = 3
    logic        b_req;
    logic [63:0] b_pc;
    logic [63:0] b_a7;
    logic        b_idle;
    logic [63:0] b_result;
    logic        b_ack, b_stall, b_drain, b_trig, b_we, b_flush, b_rv, b_halt;
    logic [4:0]  b_waddr;
    logic [63:0] b_wdata, b_rpc;
    logic [31:0] b_count;

    int checks   = 0;
    int failures = 0;

    ecall_sequencer #(.RESULT_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .ecall_req(req), .ecall_pc(pc), .ecall_a7(a7),
        .ecall_ack(ack), .stall(stall), .mem_drain_req(drain),
        .mem_idle(idle), .ecall_trigger(trig), .ecall_result(result),
        .rf_we(we), .rf_waddr(waddr), .rf_wdata(wdata),
        .flush(flush), .redirect_valid(rv), .redirect_pc(rpc),
        .halt(halt), .ecall_count(count)
    );

    ecall_sequencer #(.RESULT_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .ecall_req(b_req), .ecall_pc(b_pc), .ecall_a7(b_a7),
        .ecall_ack(b_ack), .stall(b_stall), .mem_drain_req(b_drain),
        .mem_idle(b_idle), .ecall_trigger(b_trig), .ecall_result(b_result),
        .rf_we(b_we), .rf_waddr(b_waddr), .rf_wdata(b_wdata),
        .flush(b_flush), .redirect_valid(b_rv), .redirect_pc(b_rpc),
        .halt(b_halt), .ecall_count(b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of stimulus and expected outputs.
    // flags = {ack, stall, drain, trig, we, flush, rv, halt}
    typedef struct packed {
        logic        req;
        logic [63:0] pc;
        logic [63:0] a7;
        logic        idle;
        logic [63:0] result;
        logic [7:0]  flags;
        logic [63:0] wdata;   // compared only when we is expected
        logic [63:0] rpc;     // compared only when rv is expected
        logic [31:0] count;
    } vec_t;

    function automatic vec_t mk(input logic req_i, input logic [63:0] pc_i,
                                input logic [63:0] a7_i, input logic idle_i,
                                input logic [63:0] res_i, input logic [7:0] fl,
                                input logic [63:0] wd, input logic [63:0] rp,
                                input logic [31:0] cnt);
        vec_t v;
        v.req = req_i; v.pc = pc_i; v.a7 = a7_i; v.idle = idle_i;
        v.result = res_i; v.flags = fl; v.wdata = wd; v.rpc = rp;
        v.count = cnt;
        return v;
    endfunction

    task automatic chk(input string tag, input string field,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", tag, field, act, exp);
        end
    endtask

    // At the negedge: compare current-cycle outputs, then drive the inputs
    // that the next posedge will sample.
    task automatic run_row(input vec_t v, input string tag);
        @(negedge clk);
        chk(tag, "ack",   64'(ack),   64'(v.flags[7]));
        chk(tag, "stall", 64'(stall), 64'(v.flags[6]));
        chk(tag, "drain", 64'(drain), 64'(v.flags[5]));
        chk(tag, "trig",  64'(trig),  64'(v.flags[4]));
        chk(tag, "we",    64'(we),    64'(v.flags[3]));
        chk(tag, "waddr", 64'(waddr), v.flags[3] ? 64'd10 : 64'd0);
        chk(tag, "flush", 64'(flush), 64'(v.flags[2]));
        chk(tag, "rv",    64'(rv),    64'(v.flags[1]));
        chk(tag, "halt",  64'(halt),  64'(v.flags[0]));
        chk(tag, "count", 64'(count), 64'(v.count));
        if (v.flags[3]) chk(tag, "wdata", wdata, v.wdata);
        if (v.flags[1]) chk(tag, "rpc",   rpc,   v.rpc);
        $display("cycle %s req=%0d ack=%0d stall=%0d trig=%0d we=%0d rv=%0d halt=%0d count=%0d",
                 tag, req, ack, stall, trig, we, rv, halt, count);
        req    = v.req;
        pc     = v.pc;
        a7     = v.a7;
        idle   = v.idle;
        result = v.result;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, "ack",   64'(ack),   64'd0);
        chk(tag, "stall", 64'(stall), 64'd0);
        chk(tag, "drain", 64'(drain), 64'd0);
        chk(tag, "trig",  64'(trig),  64'd0);
        chk(tag, "we",    64'(we),    64'd0);
        chk(tag, "waddr", 64'(waddr), 64'd0);
        chk(tag, "wdata", wdata,      64'd0);
        chk(tag, "flush", 64'(flush), 64'd0);
        chk(tag, "rv",    64'(rv),    64'd0);
        chk(tag, "rpc",   rpc,        64'd0);
        chk(tag, "halt",  64'(halt),  64'd0);
        chk(tag, "count", 64'(count), 64'd0);
        $display("cycle %s all outputs expected zero", tag);
    endtask

    vec_t vecs [15];

    initial begin
        reset = 1'b0;
        req = 1'b0; pc = '0; a7 = '0; idle = 1'b1; result = '0;
        b_req = 1'b0; b_pc = '0; b_a7 = '0; b_idle = 1'b1; b_result = '0;

        // Basic call (pc 0x1000, a7 64, result 5) then a back-to-back call
        // requested in the cycle right after the first redirect.
        vecs[0]  = mk(1'b1, 64'h1000, 64'd64, 1'b1, 64'hDEAD, 8'b00000000, 64'd0,  64'd0,     32'd0);
        vecs[1]  = mk(1'b1, 64'h1000, 64'd64, 1'b1, 64'hDEAD, 8'b11100000, 64'd0,  64'd0,     32'd0);
        vecs[2]  = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01100000, 64'd0,  64'd0,     32'd0);
        vecs[3]  = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01010000, 64'd0,  64'd0,     32'd0);
        vecs[4]  = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'h5,    8'b01000000, 64'd0,  64'd0,     32'd0);
        vecs[5]  = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01001000, 64'h5,  64'd0,     32'd0);
        vecs[6]  = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01000110, 64'd0,  64'h1004,  32'd0);
        vecs[7]  = mk(1'b1, 64'h2000, 64'd1,  1'b1, 64'hDEAD, 8'b00000000, 64'd0,  64'd0,     32'd1);
        vecs[8]  = mk(1'b1, 64'h2000, 64'd1,  1'b1, 64'hDEAD, 8'b11100000, 64'd0,  64'd0,     32'd1);
        vecs[9]  = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01100000, 64'd0,  64'd0,     32'd1);
        vecs[10] = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01010000, 64'd0,  64'd0,     32'd1);
        vecs[11] = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'h77,   8'b01000000, 64'd0,  64'd0,     32'd1);
        vecs[12] = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01001000, 64'h77, 64'd0,     32'd1);
        vecs[13] = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01000110, 64'd0,  64'h2004,  32'd1);
        vecs[14] = mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b00000000, 64'd0,  64'd0,     32'd2);

        // Reset state
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_row(vecs[i], $sformatf("tbl%0d", i));
        end

        // Drain hold: mem_idle low for 7 cycles after accept.
        run_row(mk(1'b1, 64'h3000, 64'd5, 1'b0, 64'hDEAD, 8'b00000000, 64'd0, 64'd0, 32'd2), "drn_req");
        for (int k = 0; k < 8; k++) begin
            run_row(mk(k == 0, (k == 0) ? 64'h3000 : 64'h0, (k == 0) ? 64'd5 : 64'd0,
                       k == 7, 64'hDEAD, (k == 0) ? 8'b11100000 : 8'b01100000,
                       64'd0, 64'd0, 32'd2), $sformatf("drn%0d", k));
        end
        run_row(mk(1'b0, 64'h0, 64'd0, 1'b1, 64'hDEAD, 8'b01010000, 64'd0,  64'd0,    32'd2), "drn_trig");
        run_row(mk(1'b0, 64'h0, 64'd0, 1'b1, 64'h99,   8'b01000000, 64'd0,  64'd0,    32'd2), "drn_wait");
        run_row(mk(1'b0, 64'h0, 64'd0, 1'b1, 64'hDEAD, 8'b01001000, 64'h99, 64'd0,    32'd2), "drn_wb");
        run_row(mk(1'b0, 64'h0, 64'd0, 1'b1, 64'hDEAD, 8'b01000110, 64'd0,  64'h3004, 32'd2), "drn_red");
        run_row(mk(1'b0, 64'h0, 64'd0, 1'b1, 64'hDEAD, 8'b00000000, 64'd0,  64'd0,    32'd3), "drn_idle");

        // Latency 3 and pc wrap on the second instance.
        @(negedge clk);
        b_req = 1'b1; b_pc = 64'hFFFF_FFFF_FFFF_FFFC; b_a7 = 64'd1; b_idle = 1'b1; b_result = 64'hDEAD;
        @(negedge clk);
        chk("lat3_c0", "ack", 64'(b_ack), 64'd1);
        b_req = 1'b0;
        @(negedge clk);
        chk("lat3_c1", "drain", 64'(b_drain), 64'd1);
        @(negedge clk);
        chk("lat3_c2", "trig", 64'(b_trig), 64'd1);
        b_result = 64'hA0;
        @(negedge clk);
        chk("lat3_c3", "trig", 64'(b_trig), 64'd0);
        chk("lat3_c3", "we", 64'(b_we), 64'd0);
        b_result = 64'hA1;
        @(negedge clk);
        chk("lat3_c4", "we", 64'(b_we), 64'd0);
        b_result = 64'hA2;
        @(negedge clk);
        chk("lat3_c5", "we", 64'(b_we), 64'd0);
        b_result = 64'h1234;
        @(negedge clk);
        chk("lat3_c6", "we", 64'(b_we), 64'd1);
        chk("lat3_c6", "waddr", 64'(b_waddr), 64'd10);
        chk("lat3_c6", "wdata", b_wdata, 64'h1234);
        b_result = 64'hBB;
        @(negedge clk);
        chk("lat3_c7", "rv", 64'(b_rv), 64'd1);
        chk("lat3_c7", "flush", 64'(b_flush), 64'd1);
        chk("lat3_c7", "rpc", b_rpc, 64'h0);
        @(negedge clk);
        chk("lat3_c8", "stall", 64'(b_stall), 64'd0);
        chk("lat3_c8", "count", 64'(b_count), 64'd1);
        $display("cycle lat3 wdata=%h rpc=%h count=%0d", b_wdata, b_rpc, b_count);

        // Exit syscall: normal writeback/redirect, then sticky halt, no ack.
        run_row(mk(1'b1, 64'h4000, 64'd93, 1'b1, 64'hDEAD, 8'b00000000, 64'd0, 64'd0,    32'd3), "ex_req");
        run_row(mk(1'b1, 64'h4000, 64'd93, 1'b1, 64'hDEAD, 8'b11100000, 64'd0, 64'd0,    32'd3), "ex_ack");
        run_row(mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01100000, 64'd0, 64'd0,    32'd3), "ex_drn");
        run_row(mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01010000, 64'd0, 64'd0,    32'd3), "ex_trig");
        run_row(mk(1'b0, 64'h0,    64'd0,  1'b1, 64'h0,    8'b01000000, 64'd0, 64'd0,    32'd3), "ex_wait");
        run_row(mk(1'b0, 64'h0,    64'd0,  1'b1, 64'hDEAD, 8'b01001000, 64'd0, 64'd0,    32'd3), "ex_wb");
        run_row(mk(1'b1, 64'h5555, 64'd1,  1'b1, 64'hDEAD, 8'b01000110, 64'd0, 64'h4004, 32'd3), "ex_red");
        for (int k = 0; k < 6; k++) begin
            run_row(mk(1'b1, 64'h5555, 64'd1, 1'b1, 64'hDEAD, 8'b01000001, 64'd0, 64'd0, 32'd4),
                    $sformatf("halted%0d", k));
        end

        // Reset leaves HALTED; then a call abandoned by reset during WAIT.
        @(negedge clk);
        reset = 1'b0;
        req = 1'b0;
        @(negedge clk);
        check_zero("rst_halt");
        reset = 1'b1;
        run_row(mk(1'b1, 64'h6000, 64'd7, 1'b1, 64'hDEAD, 8'b00000000, 64'd0, 64'd0, 32'd0), "rc_req");
        run_row(mk(1'b1, 64'h6000, 64'd7, 1'b1, 64'hDEAD, 8'b11100000, 64'd0, 64'd0, 32'd0), "rc_ack");
        run_row(mk(1'b0, 64'h0,    64'd0, 1'b1, 64'hDEAD, 8'b01100000, 64'd0, 64'd0, 32'd0), "rc_drn");
        run_row(mk(1'b0, 64'h0,    64'd0, 1'b1, 64'hDEAD, 8'b01010000, 64'd0, 64'd0, 32'd0), "rc_trig");
        run_row(mk(1'b0, 64'h0,    64'd0, 1'b1, 64'h42,   8'b01000000, 64'd0, 64'd0, 32'd0), "rc_wait");
        reset = 1'b0;
        @(negedge clk);
        check_zero("rc_abandon");
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            run_row(mk(1'b0, 64'h0, 64'd0, 1'b1, 64'h42, 8'b00000000, 64'd0, 64'd0, 32'd0),
                    $sformatf("rc_after%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
